vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 raster timing from the 25 MHz pixel clock.
- Drives the pixel coordinates consumed by the pattern generators (four-colour bars and similar).
- Takes back their combinational 4-bit RGB and registers it onto the connector pins with blanking applied.
- Keeps HSYNC, VSYNC and RGB phase-aligned at the pins.

Parameters:
- HVID, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYNC, 96, horizontal sync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VVID, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- HS_POL, 0, active level of vga_hs (0 = active-low)
- VS_POL, 0, active level of vga_vs (0 = active-low)

Ports:
- clk_25  input  1  pixel clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- red_in  input  4  pattern red for current horizontal_num/vertical_num
- green_in  input  4  pattern green
- blue_in  input  4  pattern blue
- horizontal_num  output  10  current pixel column (stage-0 counter)
- vertical_num  output  10  current line (stage-0 counter)
- video_on  output  1  stage-0 visible-region flag
- frame_start  output  1  one-cycle pulse at pixel (0,0), stage 0
- vga_hs  output  1  horizontal sync pin (stage 1)
- vga_vs  output  1  vertical sync pin (stage 1)
- vga_r  output  4  red pin (stage 1)
- vga_g  output  4  green pin (stage 1)
- vga_b  output  4  blue pin (stage 1)

Behaviour:
- Derived constants:
  - HTOTAL = HVID+HFP+HSYNC+HBP (800); VTOTAL = VVID+VFP+VSYNC+VBP (525).
  - Both must be ≤1024; elaboration error otherwise.
- Stage 0 (counters, registers):
  - h_cnt increments every clk_25.
  - At HTOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps to 0 when h_cnt=HTOTAL-1 and v_cnt=VTOTAL-1; it never exceeds VTOTAL-1.
  - horizontal_num = h_cnt; vertical_num = v_cnt (direct register outputs).
- Stage-0 decodes:
  - video_on = (h_cnt<HVID) && (v_cnt<VVID).
  - frame_start = (h_cnt==0) && (v_cnt==0).
  - hs_act = h_cnt in [HVID+HFP, HVID+HFP+HSYNC-1] (656..751).
  - vs_act = v_cnt in [VVID+VFP, VVID+VFP+VSYNC-1] (490..491); line-based, toggles with the h_cnt wrap.
- Stage 1 (output registers, 1-cycle latency from stage 0):
  - vga_hs <= hs_act ? HS_POL : ~HS_POL.
  - vga_vs <= vs_act ? VS_POL : ~VS_POL.
  - {vga_r,vga_g,vga_b} <= video_on ? {red_in,green_in,blue_in} : 0.
- Pattern contract:
  - red_in/green_in/blue_in are sampled in the same cycle as the horizontal_num that produced them (combinational pattern path).
  - Registered pattern generators are out of scope.
- Reset (synchronous, takes priority over counting):
  - h_cnt=0, v_cnt=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL (inactive), vga_r/g/b=0.
- Outputs during and after reset:
  - Combinational stage-0 outputs follow the counters; during reset and in the cycle after, frame_start=1 and video_on=1.
  - Stage 1 updates from the first clock after reset deasserts: pins show pixel (0,0) colour one cycle after reset release.
- Reset mid-frame: counters return to 0 on the next edge; no partial-line completion, no sync stretch beyond the reset cycle.
- Blanking: RGB pins are 0 for all h≥HVID or v≥VVID regardless of colour inputs.
- Mid-line sync: vga_vs asserts and deasserts coincident with line start (stage 1), not mid-line.

Test Plan:
- Reset, then release at t0 -> horizontal_num 0,1,2,… each cycle; wraps 799->0 with vertical_num +1; frame_start high at t0 and exactly every 420000 cycles after.
- Free-run one line -> vga_hs low exactly 96 consecutive cycles, falling edge one cycle after horizontal_num==656, rising one cycle after horizontal_num==752.
- Free-run one frame -> vga_vs low exactly 1600 cycles (2 lines), falling one cycle after (h=0, v=490).
- Drive red_in=F, green_in=F, blue_in=F constantly -> pins 0xF only on cycles following video_on=1; 0 at h=640..799 and lines 480..524; 307200 lit cycles per frame.
- Connect the four-colour bar generator -> vga_r/g/b = F00 for stage-1 columns 0..159, 0F0 for 160..319, 00F for 320..479, FFF for 480..639, 000 otherwise.
- Assert reset for 3 cycles at (h=300, v=200) -> pins go inactive/0 the next edge; after release counting restarts at (0,0) with frame_start pulse; no spurious sync pulse.

Source files
------------

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator with registered, blanked RGB/sync pins
module vga_sync_gen #(
  parameter int HVID   = 640,
  parameter int HFP    = 16,
  parameter int HSYNC  = 96,
  parameter int HBP    = 48,
  parameter int VVID   = 480,
  parameter int VFP    = 10,
  parameter int VSYNC  = 2,
  parameter int VBP    = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int HTOTAL = HVID + HFP + HSYNC + HBP;
  localparam int VTOTAL = VVID + VFP + VSYNC + VBP;

  // Counters are 10 bits wide, so a raster larger than 1024 in either axis cannot be represented.
  if (HTOTAL > 1024 || VTOTAL > 1024) begin : g_bad_geometry
    $error("vga_sync_gen: HTOTAL/VTOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST    = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(VTOTAL - 1);
  localparam logic [9:0] H_VID     = 10'(HVID);
  localparam logic [9:0] V_VID     = 10'(VVID);
  localparam logic [9:0] HS_START  = 10'(HVID + HFP);
  localparam logic [9:0] HS_END    = 10'(HVID + HFP + HSYNC - 1);
  localparam logic [9:0] VS_START  = 10'(VVID + VFP);
  localparam logic [9:0] VS_END    = 10'(VVID + VFP + VSYNC - 1);

  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic [11:0] r_rgb;

  logic        w_video_on;
  logic        w_frame_start;
  logic        w_hs_act;
  logic        w_vs_act;

  // Stage 0: pixel counter wraps at end of line and advances the line counter, which wraps at end of frame.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      if (r_v_cnt == V_LAST) begin
        r_v_cnt <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Stage-0 decodes of the current raster position; vsync is purely line-based so it changes only at the line wrap.
  always_comb begin
    w_video_on    = (r_h_cnt < H_VID) && (r_v_cnt < V_VID);
    w_frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    w_hs_act      = (r_h_cnt >= HS_START) && (r_h_cnt <= HS_END);
    w_vs_act      = (r_v_cnt >= VS_START) && (r_v_cnt <= VS_END);
  end

  // Stage 1: syncs and blanked colour registered together so all pins share the same one-cycle latency.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs  <= w_vs_act ? VS_POL : ~VS_POL;
      r_rgb <= w_video_on ? {red_in, green_in, blue_in} : 12'd0;
    end
  end

  assign horizontal_num = r_h_cnt;
  assign vertical_num   = r_v_cnt;
  assign video_on       = w_video_on;
  assign frame_start    = w_frame_start;
  assign vga_hs         = r_hs;
  assign vga_vs         = r_vs;
  assign vga_r          = r_rgb[11:8];
  assign vga_g          = r_rgb[7:4];
  assign vga_b          = r_rgb[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized self-checking bench for vga_sync_gen on a reduced raster
module tb_vga_sync_gen;

  localparam int HVID = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VVID = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HVID + HFP + HSY + HBP;
  localparam int VT = VVID + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;

  logic       clk_25 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] red_in = '0, green_in = '0, blue_in = '0;
  logic [9:0] horizontal_num, vertical_num;
  logic       video_on, frame_start, vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_sync_gen #(
    .HVID(HVID), .HFP(HFP), .HSYNC(HSY), .HBP(HBP),
    .VVID(VVID), .VFP(VFP), .VSYNC(VSY), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk_25(clk_25), .reset(reset),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .horizontal_num(horizontal_num), .vertical_num(vertical_num),
    .video_on(video_on), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #20 clk_25 = ~clk_25;

  int total = 0;
  int bad = 0;

  // model: n = cycles since the position (0,0) was first shown after reset
  int n = 0;
  logic        exp_hs, exp_vs;
  logic [11:0] exp_rgb;
  int cnt_fs, cnt_vid, cnt_hs, cnt_vs;

  function automatic int hpos(input int k); return k % HT; endfunction
  function automatic int vpos(input int k); return (k / HT) % VT; endfunction
  function automatic bit vis(input int k); return (hpos(k) < HVID) && (vpos(k) < VVID); endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input bit all_f);
    int nn;
    logic nhs, nvs;
    logic [11:0] nrgb;
    int h, v;
    reset = rst;
    if (all_f) begin
      red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF;
    end else begin
      red_in = 4'($urandom); green_in = 4'($urandom); blue_in = 4'($urandom);
    end
    if (rst) begin
      nn = 0; nhs = ~HS_POL; nvs = ~VS_POL; nrgb = '0;
    end else begin
      h = hpos(n); v = vpos(n);
      nn = n + 1;
      nhs = (h >= HVID + HFP && h < HVID + HFP + HSY) ? HS_POL : ~HS_POL;
      nvs = (v >= VVID + VFP && v < VVID + VFP + VSY) ? VS_POL : ~VS_POL;
      nrgb = vis(n) ? {red_in, green_in, blue_in} : 12'd0;
    end
    @(posedge clk_25);
    #1;
    n = nn; exp_hs = nhs; exp_vs = nvs; exp_rgb = nrgb;
    chk("h_num", int'(horizontal_num), hpos(n));
    chk("v_num", int'(vertical_num), vpos(n));
    chk("video_on", int'(video_on), int'(vis(n)));
    chk("frame_start", int'(frame_start), int'(hpos(n) == 0 && vpos(n) == 0));
    chk("vga_hs", int'(vga_hs), int'(exp_hs));
    chk("vga_vs", int'(vga_vs), int'(exp_vs));
    chk("vga_rgb", int'({vga_r, vga_g, vga_b}), int'(exp_rgb));
    if (rst) begin
      cnt_fs = 0; cnt_vid = 0; cnt_hs = 0; cnt_vs = 0;
    end
    if (n < 2 * FT) begin
      cnt_fs  += int'(frame_start);
      cnt_vid += int'(video_on);
    end
    if (n >= 1 && n <= 2 * FT) begin
      cnt_hs += int'(vga_hs == HS_POL);
      cnt_vs += int'(vga_vs == VS_POL);
    end
  endtask

  task automatic check_window_counts();
    chk("frame_start_count", cnt_fs, 2);
    chk("video_on_count", cnt_vid, 2 * HVID * VVID);
    chk("hs_active_count", cnt_hs, 2 * VT * HSY);
    chk("vs_active_count", cnt_vs, 2 * VSY * HT);
  endtask

  initial begin
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    // random colours, occasionally solid white to exercise blanking on full-scale input
    for (int i = 0; i < 2 * FT + 40; i++) step(1'b0, $urandom_range(0, 3) == 0);
    check_window_counts();
    // wander to a random mid-frame position, then hold reset for 3 cycles
    for (int i = 0; i < int'($urandom_range(5, FT)); i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 2 * FT + 10; i++) step(1'b0, $urandom_range(0, 1) == 0);
    check_window_counts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
